// File: rtl/slot_irq_ctrl_if.sv
// Register-window bus between the SPI register slave (master) and slot_irq_ctrl (slave).
// Writes are single-cycle strobes; reads return registered data one edge after rd_addr.
interface slot_irq_ctrl_if;
  logic        wr_stb;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;

  modport master (output wr_stb, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_stb, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/slot_irq_ctrl.sv
// Slot GPIO interrupt controller: synchronised any-edge capture into masked per-slot
// pending registers, round-robin service scheduler, and mask/clear/pending/status windows.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | irq low, pick next pending slot searching up from last+1
// ST_SERVE | irq high, irq_slot frozen until its pending word is zero
// ST_GAP   | irq low for one cycle so every service ends in a visible drop
module slot_irq_ctrl #(
  parameter int N_SLOTS = 8,
  parameter int SLOT_W  = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [N_SLOTS*SLOT_W-1:0] slot_in,
  input  logic [N_SLOTS*SLOT_W-1:0] slot_dir,
  slot_irq_ctrl_if.slave            bus,
  output logic                      irq,
  output logic [2:0]                irq_slot
);

  localparam int W = N_SLOTS * SLOT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  logic [W-1:0]        sync1_q, sync2_q, prev_q;
  logic [W-1:0]        chg;
  logic [1:0]          arm_q, arm_d;
  logic                armed;

  logic [SLOT_W-1:0]   mask_q [N_SLOTS];
  logic [SLOT_W-1:0]   mask_d [N_SLOTS];
  logic [SLOT_W-1:0]   pend_q [N_SLOTS];
  logic [SLOT_W-1:0]   pend_d [N_SLOTS];
  logic [N_SLOTS-1:0]  pend_nz;

  state_t              state_q, state_d;
  logic [2:0]          slot_q, slot_d;
  logic [2:0]          last_q, last_d;
  logic                irq_q, irq_d;
  logic [15:0]         rd_q, rd_d;

  logic [2:0]          wr_s, rd_s;
  logic                wr_ok, wr_mask, wr_clr;
  logic [2:0]          pick;
  logic                found;

  // Arm timer counts down from 3; detection opens once the synchroniser and prev are primed.
  assign armed = (arm_q == 2'd0);
  assign arm_d = armed ? arm_q : arm_q - 2'd1;
  assign chg   = armed ? (sync2_q ^ prev_q) : '0;

  assign wr_s    = bus.wr_addr[2:0];
  assign wr_ok   = bus.wr_stb && (int'(wr_s) < N_SLOTS);
  assign wr_mask = wr_ok && (bus.wr_addr[7:3] == 5'b00100);
  assign wr_clr  = wr_ok && (bus.wr_addr[7:3] == 5'b00101);

  always_comb begin
    logic [SLOT_W-1:0] clr;
    clr = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      clr        = (wr_clr && (int'(wr_s) == s)) ? bus.wr_data[SLOT_W-1:0] : '0;
      pend_d[s]  = (pend_q[s] & ~clr)
                 | (chg[s*SLOT_W +: SLOT_W] & mask_q[s] & ~slot_dir[s*SLOT_W +: SLOT_W]);
      mask_d[s]  = (wr_mask && (int'(wr_s) == s)) ? bus.wr_data[SLOT_W-1:0] : mask_q[s];
      pend_nz[s] = |pend_q[s];
    end
  end

  // Round-robin search: walking offsets downward lets the nearest slot after last win.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = slot_q;
    found = 1'b0;
    for (int i = N_SLOTS; i >= 1; i--) begin
      idx = int'(last_q) + i;
      if (idx >= N_SLOTS) idx = idx - N_SLOTS;
      if (pend_nz[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_SERVE;
          slot_d  = pick;
        end
      end
      ST_SERVE: begin
        if (!pend_nz[slot_q]) begin
          last_d  = slot_q;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_SERVE);
  end

  // Readback reflects register state before any write on the same edge.
  always_comb begin
    logic [7:0] nz8;
    nz8               = '0;
    nz8[N_SLOTS-1:0]  = pend_nz;
    rd_d              = '0;
    rd_s              = bus.rd_addr[2:0];
    if (int'(rd_s) < N_SLOTS) begin
      case (bus.rd_addr[7:3])
        5'b00100: rd_d = 16'(mask_q[rd_s]);
        5'b00110: rd_d = 16'(pend_q[rd_s]);
        default:  rd_d = '0;
      endcase
    end
    if (bus.rd_addr == 8'h38) rd_d = {irq_q, 4'b0000, slot_q, nz8};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= 2'd3;
      for (int s = 0; s < N_SLOTS; s++) begin
        mask_q[s] <= '0;
        pend_q[s] <= '0;
      end
      state_q <= ST_IDLE;
      slot_q  <= '0;
      last_q  <= 3'(N_SLOTS - 1);
      irq_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      sync1_q <= slot_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= arm_d;
      for (int s = 0; s < N_SLOTS; s++) begin
        mask_q[s] <= mask_d[s];
        pend_q[s] <= pend_d[s];
      end
      state_q <= state_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
      irq_q   <= irq_d;
      rd_q    <= rd_d;
    end
  end

  assign irq         = irq_q;
  assign irq_slot    = slot_q;
  assign bus.rd_data = rd_q;

endmodule
